spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0-3 (CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]).
REQ-002 SHALL have parameter IDLE_TX_BYTE, default 8'hFF, meaning the byte shifted out on MISO when no TX byte is queued.
REQ-003 SHALL have port i_Clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port i_Rst_L  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_SPI_Clk  input  1  SPI clock from the master; asynchronous to i_Clk.
REQ-006 SHALL have port i_SPI_CS_n  input  1  chip select from the master; active-low; asynchronous.
REQ-007 SHALL have port i_SPI_MOSI  input  1  serial data from the master; asynchronous.
REQ-008 SHALL have port o_SPI_MISO  output  1  serial data to the master.
REQ-009 SHALL have port o_SPI_MISO_En  output  1  MISO drive enable for the pad tristate; high only while selected.
REQ-010 SHALL have port i_TX_Byte  input  8  byte to return on MISO.
REQ-011 SHALL have port i_TX_DV  input  1  one-cycle strobe qualifying i_TX_Byte.
REQ-012 SHALL have port o_TX_Ready  output  1  TX holding register empty; can accept i_TX_DV.
REQ-013 SHALL have port o_RX_DV  output  1  one-cycle pulse: o_RX_Byte is valid.
REQ-014 SHALL have port o_RX_Byte  output  8  last complete byte received on MOSI, MSB first.

Function
REQ-015 SHALL pass i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI through 2-flop synchronizers; all edge detection uses the synchronized values. Operation requires i_Clk >= 8x the SPI clock frequency.
REQ-016 SHALL define the leading edge as rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite edge.
REQ-017 SHALL sample MOSI on the leading edge when CPHA=0 and on the trailing edge when CPHA=1.
REQ-018 SHALL change MISO on the trailing edge when CPHA=0 and on the leading edge when CPHA=1.
REQ-019 SHALL, when CPHA=0, present the MSB of the loaded byte on MISO within 3 i_Clk cycles of CS_n falling at the pin.
REQ-020 SHALL implement the states IDLE (CS_n high) and ACTIVE (CS_n low).
  - Transition IDLE->ACTIVE on the synchronized CS_n falling edge.
  - Transition ACTIVE->IDLE on the synchronized CS_n rising edge.
REQ-021 SHALL keep a 3-bit sample counter that increments on each sampling edge in ACTIVE and wraps from 7 to 0, so back-to-back bytes within one CS_n assertion are supported.
REQ-022 SHALL, on the 8th sample, update o_RX_Byte and pulse o_RX_DV for exactly 1 cycle, 1 cycle after the synchronized sampling edge is detected. o_RX_Byte holds its value until the next complete byte.
REQ-023 SHALL define o_TX_Ready = holding register empty.
  - i_TX_DV while o_TX_Ready=1 loads the holding register; o_TX_Ready falls the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored.
REQ-024 SHALL move the holding register into the TX shift register at every byte start (CS_n fall, or counter wrap to 0); o_TX_Ready rises the next cycle.
  - If the holding register is empty at byte start, IDLE_TX_BYTE is shifted instead.
REQ-025 SHALL, when i_TX_DV coincides with a byte-start transfer, transfer the old holding value and capture the new byte, leaving o_TX_Ready=0.
REQ-026 SHALL, on CS_n rising mid-byte, discard the partial byte (no o_RX_DV) and reset the counter to 0; the holding register content is retained.
REQ-027 SHALL drive o_SPI_MISO_En = 1 only in ACTIVE. o_SPI_MISO is the shift register MSB and is 1 in IDLE.

Reset
REQ-028 SHALL, while i_Rst_L=0, asynchronously force the following values:
  - state IDLE, counter 0
  - o_RX_DV=0, o_RX_Byte=8'h00
  - o_TX_Ready=1, holding register empty
  - o_SPI_MISO=1, o_SPI_MISO_En=0
  - synchronizer flops: CS_n=1, SPI_Clk=CPOL, MOSI=0
REQ-029 SHALL treat reset released with CS_n already low as IDLE until a fresh CS_n falling edge occurs.

Structure
REQ-030 SHALL place the state enum, the CPOL/CPHA decode functions and the MODE constants in a shared package spi_pkg, also used by the master side.
REQ-031 SHALL implement the 2-flop synchronizer as sub-module spi_sync (parameterized width and reset value), instantiated once for the 3-bit input bus.

Verification
REQ-032 SHALL cover: mode 0, queue 8'hA5, master sends 8'h3C -> o_RX_Byte=8'h3C with a single o_RX_DV pulse; master captures 8'hA5.
REQ-033 SHALL cover: mode 3, two bytes in one CS_n (8'hBE, 8'hEF), with TX 8'h12 queued then 8'h34 on o_TX_Ready -> RX 8'hBE then 8'hEF; master gets 8'h12, 8'h34.
REQ-034 SHALL cover: nothing queued, mode 1, master sends 8'hC1 -> master receives 8'hFF; o_RX_Byte=8'hC1.
REQ-035 SHALL cover: CS_n raised after 5 bits of 8'h55, then full byte 8'h0F -> no o_RX_DV for the partial; next o_RX_Byte=8'h0F.
REQ-036 SHALL cover: i_Rst_L asserted mid-byte in mode 2 -> outputs take REQ-028 values immediately; the next full transfer of 8'h81 is received correctly.
REQ-037 SHALL cover: i_TX_DV coincident with a byte-start transfer -> both bytes transmitted in order; o_TX_Ready stays 0 through that cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: link state, mode constants and CPOL/CPHA decode.
// Used by both the slave and the master side.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int unsigned SPI_MODE0 = 0;
    localparam int unsigned SPI_MODE1 = 1;
    localparam int unsigned SPI_MODE2 = 2;
    localparam int unsigned SPI_MODE3 = 3;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = 3;

    // Bit positions of the pins inside the synchronized input bus
    localparam int unsigned SYNC_SCK  = 2;
    localparam int unsigned SYNC_CS_N = 1;
    localparam int unsigned SYNC_MOSI = 0;

    function automatic logic spi_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between a master and a slave; the master drives clock,
// select and MOSI, the slave returns MISO and its pad enable.
interface spi_slave_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_en;

    modport master (output sck, output cs_n, output mosi, input miso, input miso_en);
    modport slave  (input sck, input cs_n, input mosi, output miso, output miso_en);
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits;
// each bit has its own reset level so idle pin states are reproduced.
module spi_sync #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments so each flop captures the pre-edge value of its neighbour.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled in the i_Clk domain; single-byte
// TX holding register and byte-wide RX output with a one-cycle valid strobe.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE     = 0,
    parameter logic [7:0]  IDLE_TX_BYTE = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam logic       CPOL     = spi_cpol(2'(SPI_MODE));
    localparam logic       CPHA     = spi_cpha(2'(SPI_MODE));
    localparam logic [2:0] SYNC_RST = {CPOL, 1'b1, 1'b0};

    logic [2:0]           w_sync;
    logic                 w_sck;
    logic                 w_cs_n;
    logic                 w_mosi;

    logic                 r_sck_d;
    logic                 r_cs_n_d;
    logic [1:0]           r_flush;
    logic                 r_armed;

    spi_state_e           r_state;
    spi_state_e           w_state_nxt;
    logic [SPI_CNT_W-1:0] r_cnt;

    logic [6:0]           r_rx_shift;
    logic [7:0]           r_rx_byte;
    logic                 r_rx_dv;

    logic [7:0]           r_tx_shift;
    logic [7:0]           r_hold;
    logic                 r_hold_full;

    logic                 w_sck_rise;
    logic                 w_sck_fall;
    logic                 w_lead_edge;
    logic                 w_trail_edge;
    logic                 w_sample_edge;
    logic                 w_shift_edge;
    logic                 w_cs_fall;
    logic                 w_cs_rise;
    logic                 w_start_frame;
    logic                 w_leave_frame;
    logic                 w_do_sample;
    logic                 w_do_shift;
    logic                 w_byte_done;
    logic                 w_byte_start;
    logic                 w_tx_accept;

    spi_sync #(
        .WIDTH     (3),
        .RESET_VAL (SYNC_RST)
    ) u_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     ({i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI}),
        .o_Q     (w_sync)
    );

    assign w_sck  = w_sync[SYNC_SCK];
    assign w_cs_n = w_sync[SYNC_CS_N];
    assign w_mosi = w_sync[SYNC_MOSI];

    assign w_sck_rise    = w_sck & ~r_sck_d;
    assign w_sck_fall    = ~w_sck & r_sck_d;
    assign w_lead_edge   = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail_edge  = CPOL ? w_sck_rise : w_sck_fall;
    assign w_sample_edge = CPHA ? w_trail_edge : w_lead_edge;
    assign w_shift_edge  = CPHA ? w_lead_edge : w_trail_edge;
    assign w_cs_fall     = ~w_cs_n & r_cs_n_d;
    assign w_cs_rise     = w_cs_n & ~r_cs_n_d;

    // r_flush marks when the synchronizer holds real pin values rather than its
    // reset image; a select that was already low at reset release never arms.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sck_d  <= CPOL;
            r_cs_n_d <= 1'b1;
            r_flush  <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sck_d  <= w_sck;
            r_cs_n_d <= w_cs_n;
            r_flush  <= {r_flush[0], 1'b1};
            r_armed  <= r_armed | (r_flush[1] & w_cs_n);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first shift edge of every byte (counter at 0) is skipped: the MSB is
    // already on MISO from the byte-start load.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_leave_frame = 1'b0;
        w_do_sample   = 1'b0;
        w_do_shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt   = ST_IDLE;
                    w_leave_frame = 1'b1;
                end else begin
                    w_do_sample = w_sample_edge;
                    w_do_shift  = w_shift_edge && (r_cnt != '0);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_byte_done  = w_do_sample && (r_cnt == 3'd7);
    assign w_byte_start = w_start_frame | w_byte_done;
    assign w_tx_accept  = i_TX_DV & (~r_hold_full | w_byte_start);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_dv <= w_byte_done;
            if (w_leave_frame) begin
                r_cnt <= '0;
            end else if (w_do_sample) begin
                r_cnt      <= r_cnt + 3'd1;
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
            end
            if (w_byte_done) begin
                r_rx_byte <= {r_rx_shift, w_mosi};
            end
        end
    end

    // A strobe coinciding with a byte start is still taken: the old holding
    // value moves to the shifter in the same cycle the new byte is captured.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_shift  <= '1;
        end else begin
            if (w_tx_accept) begin
                r_hold      <= i_TX_Byte;
                r_hold_full <= 1'b1;
            end else if (w_byte_start) begin
                r_hold_full <= 1'b0;
            end
            if (w_byte_start) begin
                r_tx_shift <= r_hold_full ? r_hold : IDLE_TX_BYTE;
            end else if (w_do_shift) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
        end
    end

    assign o_SPI_MISO    = (r_state == ST_ACTIVE) ? r_tx_shift[7] : 1'b1;
    assign o_SPI_MISO_En = (r_state == ST_ACTIVE);
    assign o_TX_Ready    = ~r_hold_full;
    assign o_RX_DV       = r_rx_dv;
    assign o_RX_Byte     = r_rx_byte;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one instance per SPI mode on a shared bus,
// a master BFM, and a queue-based model of the TX holding register.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int         HALF      = 60;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic [7:0] tx_byte;
    logic       tx_dv;

    logic [3:0] w_cs_n;
    logic [3:0] w_tx_dv;
    logic [3:0] w_miso;
    logic [3:0] w_miso_en;
    logic [3:0] w_tx_ready;
    logic [3:0] w_rx_dv;
    logic [7:0] w_rx_byte [4];

    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];
    logic [7:0] miso_cap[$];
    logic [7:0] model_hold[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_dv = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if u_bus ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign w_cs_n[g]  = (sel == 2'(g)) ? u_bus.cs_n : 1'b1;
        assign w_tx_dv[g] = tx_dv && (sel == 2'(g));
        spi_slave #(
            .SPI_MODE     (g),
            .IDLE_TX_BYTE (IDLE_BYTE)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst_L       (rst_n),
            .i_SPI_Clk     (u_bus.sck),
            .i_SPI_CS_n    (w_cs_n[g]),
            .i_SPI_MOSI    (u_bus.mosi),
            .o_SPI_MISO    (w_miso[g]),
            .o_SPI_MISO_En (w_miso_en[g]),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (w_tx_dv[g]),
            .o_TX_Ready    (w_tx_ready[g]),
            .o_RX_DV       (w_rx_dv[g]),
            .o_RX_Byte     (w_rx_byte[g])
        );
    end

    assign u_bus.miso    = w_miso[sel];
    assign u_bus.miso_en = w_miso_en[sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Holding register model: one byte slot, drained at every byte start.
    function automatic logic [7:0] model_byte_start();
        if (model_hold.size() > 0) return model_hold.pop_front();
        return IDLE_BYTE;
    endfunction

    // Scoreboard monitor: pops expectations whenever the DUT or BFM presents data.
    always @(negedge clk) begin
        if (w_rx_dv[sel]) begin
            check("rx_dv_single_cycle", 32'(prev_dv), 32'd0);
            if (rx_exp.size() == 0) check("rx_dv_spurious", 32'(w_rx_dv[sel]), 32'd0);
            else check("rx_byte", 32'(w_rx_byte[sel]), 32'(rx_exp.pop_front()));
        end
        prev_dv = w_rx_dv[sel];
        if (miso_cap.size() > 0) begin
            if (miso_exp.size() == 0) begin
                check("miso_spurious", 32'(miso_exp.size()), 32'd1);
                void'(miso_cap.pop_front());
            end else begin
                check("miso_byte", 32'(miso_cap.pop_front()), 32'(miso_exp.pop_front()));
            end
        end
    end

    task automatic select_mode(input logic [1:0] mode);
        sel       = mode;
        u_bus.sck = mode[1];
        repeat (6) @(posedge clk);
    endtask

    task automatic tx_load(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        while (!w_tx_ready[sel] && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!w_tx_ready[sel]) begin
            check("tx_ready_timeout", 32'(w_tx_ready[sel]), 32'd1);
        end else begin
            tx_byte = b;
            tx_dv   = 1'b1;
            @(negedge clk);
            tx_dv   = 1'b0;
            model_hold.push_back(b);
        end
    endtask

    task automatic cs_low(input bit track);
        logic [7:0] b;
        b = model_byte_start();
        if (track) miso_exp.push_back(b);
        u_bus.cs_n = 1'b0;
        #HALF;
        check("miso_en_active", 32'(w_miso_en[sel]), 32'd1);
    endtask

    task automatic cs_high();
        u_bus.cs_n = 1'b1;
        #HALF;
        check("miso_en_idle", 32'(w_miso_en[sel]), 32'd0);
        check("miso_idle_high", 32'(u_bus.miso), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    task automatic spi_xfer(input logic [1:0] mode, input logic [7:0] mosi_b, input int nbits);
        logic       cpol;
        logic       cpha;
        logic [7:0] cap;
        cpol = mode[1];
        cpha = mode[0];
        cap  = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                u_bus.mosi = mosi_b[7-i];
                #HALF;
                cap[7-i]   = u_bus.miso;
                u_bus.sck  = ~cpol;
                #HALF;
                u_bus.sck  = cpol;
            end else begin
                #HALF;
                u_bus.sck  = ~cpol;
                u_bus.mosi = mosi_b[7-i];
                #HALF;
                cap[7-i]   = u_bus.miso;
                u_bus.sck  = cpol;
            end
        end
        if (nbits == 8) miso_cap.push_back(cap);
        repeat (4) @(posedge clk);
    endtask

    task automatic byte_full(input logic [1:0] mode, input logic [7:0] b, input bit last);
        logic [7:0] nxt;
        rx_exp.push_back(b);
        spi_xfer(mode, b, 8);
        nxt = model_byte_start();
        if (!last) miso_exp.push_back(nxt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run still going at time limit (got timeout, wanted completion)");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] mode;
        int         nb;
        rst_n      = 1'b0;
        sel        = 2'd0;
        tx_byte    = '0;
        tx_dv      = 1'b0;
        u_bus.sck  = 1'b0;
        u_bus.cs_n = 1'b1;
        u_bus.mosi = 1'b0;
        repeat (5) @(posedge clk);
        check("rst_rx_dv", 32'(w_rx_dv[sel]), 32'd0);
        check("rst_rx_byte", 32'(w_rx_byte[sel]), 32'h00);
        check("rst_tx_ready", 32'(w_tx_ready[sel]), 32'd1);
        check("rst_miso", 32'(w_miso[sel]), 32'd1);
        check("rst_miso_en", 32'(w_miso_en[sel]), 32'd0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Mode 0 single byte with a queued reply
        select_mode(2'd0);
        tx_load(8'hA5);
        cs_low(1'b1);
        byte_full(2'd0, 8'h3C, 1'b1);
        cs_high();
        check("rx_byte_hold_3c", 32'(w_rx_byte[sel]), 32'h3C);

        // Mode 3, two bytes in one select, second reply loaded on ready
        select_mode(2'd3);
        tx_load(8'h12);
        cs_low(1'b1);
        tx_load(8'h34);
        byte_full(2'd3, 8'hBE, 1'b0);
        byte_full(2'd3, 8'hEF, 1'b1);
        cs_high();

        // Mode 1 with nothing queued: idle byte returned
        select_mode(2'd1);
        cs_low(1'b1);
        byte_full(2'd1, 8'hC1, 1'b1);
        cs_high();
        check("rx_byte_hold_c1", 32'(w_rx_byte[sel]), 32'hC1);

        // Mode 0: select dropped after 5 bits, then a full byte
        select_mode(2'd0);
        cs_low(1'b0);
        spi_xfer(2'd0, 8'h55, 5);
        cs_high();
        cs_low(1'b1);
        byte_full(2'd0, 8'h0F, 1'b1);
        cs_high();
        check("rx_byte_after_abort", 32'(w_rx_byte[sel]), 32'h0F);

        // Mode 2: reset mid-byte, then a clean transfer
        select_mode(2'd2);
        cs_low(1'b0);
        spi_xfer(2'd2, 8'h81, 3);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_rx_dv", 32'(w_rx_dv[sel]), 32'd0);
        check("midrst_rx_byte", 32'(w_rx_byte[sel]), 32'h00);
        check("midrst_tx_ready", 32'(w_tx_ready[sel]), 32'd1);
        check("midrst_miso", 32'(w_miso[sel]), 32'd1);
        check("midrst_miso_en", 32'(w_miso_en[sel]), 32'd0);
        model_hold.delete();
        u_bus.cs_n = 1'b1;
        u_bus.sck  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        tx_load(8'h7E);
        cs_low(1'b1);
        byte_full(2'd2, 8'h81, 1'b1);
        cs_high();

        // Mode 0: TX strobe lands on the select-fall byte start
        select_mode(2'd0);
        tx_load(8'h5A);
        @(posedge clk);
        #1 u_bus.cs_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tx_byte = 8'hC3;
        tx_dv   = 1'b1;
        check("tx_ready_before_start", 32'(w_tx_ready[sel]), 32'd0);
        @(posedge clk);
        #1 tx_dv = 1'b0;
        check("tx_ready_after_coincident", 32'(w_tx_ready[sel]), 32'd0);
        miso_exp.push_back(model_byte_start());
        model_hold.push_back(8'hC3);
        #HALF;
        byte_full(2'd0, 8'h66, 1'b0);
        byte_full(2'd0, 8'h99, 1'b1);
        cs_high();

        // Randomized transactions across all modes
        for (int t = 0; t < 12; t++) begin
            mode = 2'($urandom_range(0, 3));
            nb   = int'($urandom_range(1, 3));
            select_mode(mode);
            if ($urandom_range(0, 1) == 1) tx_load(8'($urandom));
            cs_low(1'b1);
            for (int j = 0; j < nb; j++) begin
                if (j < nb - 1 && $urandom_range(0, 1) == 1) tx_load(8'($urandom));
                byte_full(mode, 8'($urandom), j == nb - 1);
            end
            cs_high();
        end

        repeat (20) @(posedge clk);
        check("rx_exp_drained", 32'(rx_exp.size()), 32'd0);
        check("miso_exp_drained", 32'(miso_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
